// File: rtl/ordering_collector_if.sv
// Ordering stream from the end of the replica chain.
// The chain drives it as master; the collector samples it as slave.
interface ordering_collector_if;
  logic            ordering_out_valid;
  logic [7:0][7:0] ordering_out_data;

  modport master (
    output ordering_out_valid,
    output ordering_out_data
  );

  modport slave (
    input ordering_out_valid,
    input ordering_out_data
  );
endinterface

// File: rtl/ordering_collector.sv
// Captures one full sweep of replica tours into a buffer,
// checks that every tour is a permutation, and serves host reads.
module ordering_collector #(
  parameter int replica_num = 32,
  parameter int city_num    = 64,
  localparam int BEATS = city_num / 8,
  localparam int DEPTH = replica_num * BEATS,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  ordering_collector_if.slave    ord,
  output logic                   capture_busy,
  output logic                   capture_done,
  output logic [replica_num-1:0] perm_error,
  output logic                   overflow,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic                   rd_valid,
  output logic [63:0]            rd_data
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW = (replica_num > 1) ? $clog2(replica_num) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [BW-1:0]          beat_q, beat_d;
  logic [RW-1:0]          rep_q, rep_d;
  logic [127:0]           seen_q, seen_d;
  logic [replica_num-1:0] perr_q, perr_d;
  logic                   ovf_q, ovf_d;
  logic                   rdv_q, rdv_d;
  logic [63:0]            rdd_q, rdd_d;

  logic [63:0] mem [DEPTH];

  logic [6:0]   city [8];
  logic [127:0] mask;
  logic         beat_err;
  logic         accept;
  logic         last_beat;
  logic         last_rep;
  logic         wr_en;
  logic [AW-1:0] wr_addr;

  always_comb begin
    for (int l = 0; l < 8; l++) begin
      city[l] = ord.ordering_out_data[l][6:0];
    end
  end

  // Out-of-range ids, repeats of earlier beats and repeats inside this beat
  always_comb begin
    beat_err = 1'b0;
    mask     = '0;
    for (int l = 0; l < 8; l++) begin
      if ({1'b0, city[l]} >= 8'(city_num)) begin
        beat_err = 1'b1;
      end else begin
        mask[city[l]] = 1'b1;
      end
      if (seen_q[city[l]]) beat_err = 1'b1;
      for (int m = 0; m < l; m++) begin
        if (city[m] == city[l]) beat_err = 1'b1;
      end
    end
  end

  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign last_rep  = (rep_q == RW'(replica_num - 1));
  assign accept    = ord.ordering_out_valid &&
                     (state_q == S_ARMED || state_q == S_CAPTURE);
  assign wr_addr   = AW'(rep_q) * AW'(BEATS) + AW'(beat_q);
  assign wr_en     = accept && reset;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    rep_d   = rep_q;
    seen_d  = seen_q;
    perr_d  = perr_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_ARMED;
          beat_d  = '0;
          rep_d   = '0;
          seen_d  = '0;
          perr_d  = '0;
          ovf_d   = 1'b0;
        end else if (ord.ordering_out_valid) begin
          ovf_d = 1'b1;
        end
      end
      S_ARMED, S_CAPTURE: begin
        if (ord.ordering_out_valid) begin
          state_d = S_CAPTURE;
          if (beat_err) perr_d[rep_q] = 1'b1;
          if (last_beat) begin
            beat_d = '0;
            seen_d = '0;
            rep_d  = last_rep ? '0 : rep_q + RW'(1);
            if (last_rep) state_d = S_DONE;
          end else begin
            beat_d = beat_q + BW'(1);
            seen_d = seen_q | mask;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Combinational array read sees the pre-edge contents on a collision
  always_comb begin
    rdv_d = rd_en;
    rdd_d = rdd_q;
    if (rd_en) begin
      if (int'({1'b0, rd_addr}) < DEPTH) rdd_d = mem[rd_addr];
      else                               rdd_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      rep_q   <= '0;
      seen_q  <= '0;
      perr_q  <= '0;
      ovf_q   <= 1'b0;
      rdv_q   <= 1'b0;
      rdd_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rep_q   <= rep_d;
      seen_q  <= seen_d;
      perr_q  <= perr_d;
      ovf_q   <= ovf_d;
      rdv_q   <= rdv_d;
      rdd_q   <= rdd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= ord.ordering_out_data;
  end

  assign capture_busy = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign capture_done = (state_q == S_DONE);
  assign perm_error   = perr_q;
  assign overflow     = ovf_q;
  assign rd_valid     = rdv_q;
  assign rd_data      = rdd_q;

endmodule

// File: tb/tb_ordering_collector.sv
// Directed bench for ordering_collector: read-back table plus
// hand-written sweeps for gaps, tour errors, overflow and mid-sweep reset.
module tb_ordering_collector;

  localparam int REP   = 32;
  localparam int CN    = 64;
  localparam int BEATS = 8;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic        busy, done, overflow, rd_valid;
  logic [31:0] perm;
  logic [63:0] rd_data;

  ordering_collector_if bus ();

  ordering_collector #(
    .replica_num(REP),
    .city_num   (CN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ord         (bus),
    .capture_busy(busy),
    .capture_done(done),
    .perm_error  (perm),
    .overflow    (overflow),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [63:0] exp;
  } rd_vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] model [DEPTH];
  rd_vec_t     vecs [5];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Lane 7 carries the earliest city of the beat
  function automatic logic [63:0] pat(input int b);
    logic [63:0] w;
    for (int l = 0; l < 8; l++) w[l*8 +: 8] = 8'(8 * b + (7 - l));
    return w;
  endfunction

  function automatic logic [63:0] mk(input int mode, input int r,
                                     input int b);
    logic [63:0] w;
    w = pat(b);
    if (mode == 3 && r == 3 && b == 5) w[7:0] = 8'd2;
    if (mode == 4 && r == 0 && b == 2) w[31:24] = 8'd64;
    if (mode == 4 && r == 1 && b == 4) w[7:0] = 8'd38;
    if (mode == 4 && r == 2 && b == 0) w[63:56] = w[63:56] | 8'h80;
    if (mode == 6) w = w | 64'h8080_8080_8080_8080;
    return w;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic rd(input int a, input logic [63:0] exp, input string nm);
    rd_en   = 1'b1;
    rd_addr = 8'(a);
    @(negedge clk);
    rd_en = 1'b0;
    chk({nm, "_valid"}, {63'd0, rd_valid}, 64'd1);
    chk(nm, rd_data, exp);
  endtask

  task automatic sweep(input int mode, input bit gap, input int nb,
                       input int rd_same, output int cyc);
    logic [63:0] d;
    logic [63:0] old;
    cyc = 0;
    old = '0;
    for (int i = 0; i < nb; i++) begin
      d = mk(mode, i / BEATS, i % BEATS);
      if (gap && i > 0) begin
        bus.ordering_out_valid = 1'b0;
        @(negedge clk);
        cyc++;
      end
      if (i == nb - 1 && nb == DEPTH)
        chk("done_early", {63'd0, done}, 64'd0);
      if (i == rd_same) begin
        rd_en   = 1'b1;
        rd_addr = 8'(i);
        old     = model[i];
      end
      bus.ordering_out_valid = 1'b1;
      bus.ordering_out_data  = d;
      model[i] = d;
      @(negedge clk);
      cyc++;
      if (i == rd_same) begin
        rd_en = 1'b0;
        chk("rd_collision", rd_data, old);
      end
      if (mode == 3 && i == 28) chk("perm_pre", {32'd0, perm}, 64'd0);
      if (mode == 3 && i == 29) chk("perm_post", {32'd0, perm}, 64'h8);
    end
    bus.ordering_out_valid = 1'b0;
  endtask

  initial begin
    int cyc;
    bus.ordering_out_valid = 1'b0;
    bus.ordering_out_data  = '0;
    vecs[0] = '{0,   64'h0001_0203_0405_0607};
    vecs[1] = '{9,   64'h0809_0a0b_0c0d_0e0f};
    vecs[2] = '{7,   64'h3839_3a3b_3c3d_3e3f};
    vecs[3] = '{255, 64'h3839_3a3b_3c3d_3e3f};
    vecs[4] = '{130, 64'h1011_1213_1415_1617};

    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_perm", {32'd0, perm}, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    chk("rst_rdv", {63'd0, rd_valid}, 64'd0);
    chk("rst_rdd", rd_data, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Beat while idle flags overflow; start clears it
    bus.ordering_out_valid = 1'b1;
    bus.ordering_out_data  = pat(0);
    @(negedge clk);
    bus.ordering_out_valid = 1'b0;
    chk("ovf_idle", {63'd0, overflow}, 64'd1);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    pulse_start();
    chk("start_ovf", {63'd0, overflow}, 64'd0);
    chk("armed_busy", {63'd0, busy}, 64'd1);

    sweep(0, 1'b0, DEPTH, -1, cyc);
    chk("t1_done", {63'd0, done}, 64'd1);
    chk("t1_busy", {63'd0, busy}, 64'd0);
    chk("t1_perm", {32'd0, perm}, 64'd0);
    chk("t1_cyc", 64'(cyc), 64'd256);
    for (int k = 0; k < 5; k++) rd(vecs[k].addr, vecs[k].exp, "t1_rd");
    @(negedge clk);
    chk("rdv_drop", {63'd0, rd_valid}, 64'd0);

    pulse_start();
    sweep(0, 1'b1, DEPTH, -1, cyc);
    chk("t2_cyc", 64'(cyc), 64'd511);
    chk("t2_done", {63'd0, done}, 64'd1);
    chk("t2_perm", {32'd0, perm}, 64'd0);
    for (int k = 0; k < 5; k++) rd(vecs[k].addr, vecs[k].exp, "t2_rd");

    pulse_start();
    chk("t3_done_clr", {63'd0, done}, 64'd0);
    sweep(3, 1'b0, DEPTH, -1, cyc);
    chk("t3_perm", {32'd0, perm}, 64'h8);
    rd(29, 64'h2829_2a2b_2c2d_2e02, "t3_rd29");

    pulse_start();
    chk("t4_perm_clr", {32'd0, perm}, 64'd0);
    sweep(4, 1'b0, DEPTH, -1, cyc);
    chk("t4_perm", {32'd0, perm}, 64'h3);
    rd(16, 64'h8001_0203_0405_0607, "t4_rd16");

    // Beat after DONE must not touch the buffer
    bus.ordering_out_valid = 1'b1;
    bus.ordering_out_data  = 64'hffff_ffff_ffff_ffff;
    @(negedge clk);
    bus.ordering_out_valid = 1'b0;
    chk("ovf_done", {63'd0, overflow}, 64'd1);
    rd(0, model[0], "ovf_rd0");
    rd(255, model[255], "ovf_rd255");
    bus.ordering_out_valid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.ordering_out_valid = 1'b0;
    chk("start_beat_ovf", {63'd0, overflow}, 64'd0);
    chk("start_beat_busy", {63'd0, busy}, 64'd1);

    // Abandon a sweep at beat 100 with a reset
    sweep(6, 1'b0, 100, -1, cyc);
    chk("t6_busy", {63'd0, busy}, 64'd1);
    chk("t6_perm", {32'd0, perm}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("t6_rst_busy", {63'd0, busy}, 64'd0);
    chk("t6_rst_done", {63'd0, done}, 64'd0);
    rd(50, 64'h9091_9293_9495_9697, "t6_rd50");
    rd(150, model[150], "t6_rd150");
    pulse_start();
    sweep(0, 1'b0, DEPTH, 50, cyc);
    chk("t6_done", {63'd0, done}, 64'd1);
    chk("t6_perm_end", {32'd0, perm}, 64'd0);
    rd(50, 64'h1011_1213_1415_1617, "t6_rd50b");
    rd(99, model[99], "t6_rd99");
    rd(200, model[200], "t6_rd200");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
